uart_receiver_controller: RTL and testbench
===========================================

UART_RECEIVER_CONTROLLER -- requirements
Module: uart_receiver_controller

Interface
REQ-001 Parameter: DATA_BITS, default 8, bits per frame.
REQ-002 Parameter: BASE_CPB, default 16, clock cycles per bit when S=2'b00.
REQ-003 Port: clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low; sampled only on clk_in rising edge.
REQ-005 Port: S  input  2  baud select; cycles per bit CPB = BASE_CPB << S, so 16/32/64/128 at default.
REQ-006 Port: ser_in  input  1  asynchronous serial line, idle high; driven by transmitter_controller ser_out.
REQ-007 Port: data_out  output  DATA_BITS  last correctly framed byte, LSB received first.
REQ-008 Port: data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 Port: frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1), no parity.
REQ-012 ser_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: on rx_s = 0, latch S into an internal copy, clear bit counter, go to START; S changes mid-frame SHALL be ignored.
REQ-015 START: after CPB/2 cycles, sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: sample rx_s every CPB cycles at mid-bit; shift into a shift register at bit index 0..DATA_BITS-1; after the last bit -> STOP.
REQ-017 STOP: after CPB cycles, sample rx_s; 1 -> load data_out, pulse data_valid, go to IDLE; 0 -> pulse frame_err, leave data_out unchanged, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s = 1, then IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 data_valid and frame_err SHALL each be high for exactly one clk_in cycle and never simultaneously.
REQ-020 Latency: data_valid SHALL rise (2 + CPB/2 + (DATA_BITS+1)*CPB) cycles after the first clk_in edge that sees ser_in low, +/-1 cycle.
REQ-021 A new start bit SHALL be accepted in the first IDLE cycle after STOP; back-to-back frames SHALL not be lost.
REQ-022 The baud counter SHALL be wide enough for CPB = BASE_CPB*8 - 1 and SHALL restart at 0 on every state transition.

Reset
REQ-023 With reset = 0 at a clk_in edge: state = IDLE, data_out = 0, data_valid = 0, frame_err = 0, busy = 0, counters and shift register = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no data_valid/frame_err pulse; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-025 Package uart_pkg SHALL hold the rx state enum, DATA_BITS/BASE_CPB defaults, and a function cpb(S) shared with transmitter_controller.
REQ-026 Sub-module uart_rx_baud_cnt SHALL implement the half/full-bit counter with load, tick_half and tick_full outputs; FSM and shift register stay in the top.

Verification
REQ-027 S=2'b00, transmitter sends 8'hA5 -> single data_valid pulse, data_out = 8'hA5, frame_err never high, busy low afterwards.
REQ-028 S=2'b10, back-to-back frames 8'hAA then 8'h3C -> two data_valid pulses 64*10 cycles apart (+/-1), data_out 8'hAA then 8'h3C.
REQ-029 S=2'b00, ser_in low for 4 cycles then high -> return to IDLE, no pulse, data_out unchanged.
REQ-030 S=2'b00, frame 8'h55 with stop bit forced 0 and line held low 500 cycles -> exactly one frame_err, no data_valid, data_out keeps previous value; next valid frame 8'h0F received correctly.
REQ-031 S changed 00 -> 11 during frame 8'hC3 -> byte received at CPB=16, data_out = 8'hC3.
REQ-032 reset = 0 for 1 cycle during bit 4 of frame 8'hFF -> no pulses; following frame 8'h81 received as 8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/baud parameters, receiver state
// encoding and the baud-select to cycles-per-bit mapping.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;
  localparam int unsigned BASE_CPB_DEF  = 16;

  // Receiver FSM state encoding.
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_STOP      = 3'd3;
  localparam rx_state_t ST_WAIT_IDLE = 3'd4;

  // Cycles per bit for baud select s: base, 2*base, 4*base or 8*base.
  function automatic int unsigned cpb(input int unsigned base, input logic [1:0] s);
    return base << s;
  endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-timing counter for the UART receiver. Restarts whenever load is high,
// flags the half-bit point and wraps at the full-bit point.
module uart_rx_baud_cnt #(
  parameter int unsigned CW = 7
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        load,
  input  logic [CW:0] cpb_cycles,
  output logic        tick_half,
  output logic        tick_full
);

  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_ext;

  assign cnt_ext   = {1'b0, cnt};
  assign tick_half = (cnt_ext == ((cpb_cycles >> 1) - 1'b1));
  assign tick_full = (cnt_ext == (cpb_cycles - 1'b1));

  // Free-running count, cleared by load or at the end of each bit period.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load || tick_full) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver_controller.sv
// 8N1 UART receiver: 2-flop input synchronizer, start-bit qualification at
// mid-bit, LSB-first data capture, stop-bit check with framing-error and
// break handling. Baud select is latched at each start bit.
module uart_receiver_controller
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned BASE_CPB  = BASE_CPB_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [1:0]           S,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(BASE_CPB * 8);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [1:0]           s_lat;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CW:0]          cpb_cycles;
  logic                 load;
  logic                 tick_half;
  logic                 tick_full;

  assign cpb_cycles = (CW + 1)'(cpb(BASE_CPB, s_lat));
  assign busy       = (state != ST_IDLE);

  uart_rx_baud_cnt #(
    .CW (CW)
  ) u_baud_cnt (
    .clk_in     (clk_in),
    .reset      (reset),
    .load       (load),
    .cpb_cycles (cpb_cycles),
    .tick_half  (tick_half),
    .tick_full  (tick_full)
  );

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= ser_in;
      rx_s    <= rx_meta;
    end
  end

  // Next-state logic; the counter is held at zero in IDLE and restarted on
  // every state change so each state times from its own entry.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) state_next = ST_START;
      end
      ST_START: begin
        if (tick_half) state_next = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick_full && (bit_idx == BW'(DATA_BITS - 1))) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick_full) state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    load = (state == ST_IDLE) || (state_next != state);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: baud latch, LSB-first shift register, output byte and pulses.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s_lat      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          if (!rx_s) s_lat <= S;
        end
        ST_DATA: begin
          if (tick_full) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + BW'(1);
          end
        end
        ST_STOP: begin
          if (tick_full) begin
            if (rx_s) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Scoreboard bench for uart_receiver_controller: a bit-level transmitter
// drives frames, queues the expected pulse (kind, byte, cycle) and a monitor
// checks every data_valid / frame_err the receiver produces.
module tb_uart_receiver_controller;

  logic       clk;
  logic       reset;
  logic [1:0] S;
  logic       ser_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_receiver_controller #(
    .DATA_BITS (8),
    .BASE_CPB  (16)
  ) dut (
    .clk_in     (clk),
    .reset      (reset),
    .S          (S),
    .ser_in     (ser_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_dout;
  int         vectors;
  int         miscompares;
  int         cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_near(string name, int act, int exp);
    vectors++;
    if (act < exp - 1 || act > exp + 1) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d expected %0d +/-1", name, act, exp);
    end
  endfunction

  // Reference bit period for a baud select value.
  function automatic int bit_cycles(input logic [1:0] s);
    return 16 * (1 << s);
  endfunction

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (data_valid || frame_err) begin
      if (data_valid && frame_err) begin
        chk("pulse_overlap", 1, 0);
      end else if (exp_q.size() == 0) begin
        chk(data_valid ? "unexpected_valid" : "unexpected_frame_err", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", int'(frame_err), int'(e.err));
        chk_near("pulse_latency", cyc, e.cyc);
        if (data_valid) begin
          chk("data_out", int'(data_out), int'(e.data));
          exp_dout = e.data;
        end else begin
          chk("data_out_kept", int'(data_out), int'(exp_dout));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmit one frame starting at the current negedge. The line is left at
  // the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input int cpb_tx,
                            input bit good_stop, input bit track);
    if (track) begin
      exp_t e;
      e.err  = !good_stop;
      e.data = d;
      e.cyc  = cyc + 1 + 2 + cpb_tx / 2 + 9 * cpb_tx;
      exp_q.push_back(e);
    end
    ser_in = 1'b0;
    idle(cpb_tx);
    for (int i = 0; i < 8; i++) begin
      ser_in = d[i];
      idle(cpb_tx);
    end
    ser_in = good_stop;
    idle(cpb_tx);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_dout    = 8'h00;
    reset       = 1'b0;
    S           = 2'b00;
    ser_in      = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(3);

    // Reset state
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_data_valid", int'(data_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);

    // Single frame at CPB=16
    send_frame(8'hA5, 16, 1'b1, 1'b1);
    idle(20);
    drain(200);
    chk("busy_after_a5", int'(busy), 0);

    // Back-to-back frames at CPB=64
    S = 2'b10;
    idle(2);
    send_frame(8'hAA, 64, 1'b1, 1'b1);
    send_frame(8'h3C, 64, 1'b1, 1'b1);
    idle(40);
    drain(1000);

    // Start-bit glitch: four cycles low
    S = 2'b00;
    idle(2);
    ser_in = 1'b0;
    idle(4);
    ser_in = 1'b1;
    idle(40);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_data_out", int'(data_out), int'(exp_dout));

    // Bad stop bit followed by a 500-cycle break, then a good frame
    send_frame(8'h55, 16, 1'b0, 1'b1);
    idle(500);
    chk("break_busy", int'(busy), 1);
    ser_in = 1'b1;
    idle(10);
    chk("after_break_busy", int'(busy), 0);
    send_frame(8'h0F, 16, 1'b1, 1'b1);
    idle(20);
    drain(200);

    // Baud select changed mid-frame is ignored
    S = 2'b00;
    idle(2);
    fork
      send_frame(8'hC3, 16, 1'b1, 1'b1);
      begin
        idle(40);
        S = 2'b11;
      end
    join
    idle(20);
    drain(200);

    // Reset pulse during data bit 4 aborts the frame silently
    S = 2'b00;
    idle(2);
    fork
      send_frame(8'hFF, 16, 1'b1, 1'b0);
      begin
        idle(16 * 5 + 8);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        exp_dout = 8'h00;
      end
    join
    idle(20);
    chk("post_reset_data_out", int'(data_out), 0);
    send_frame(8'h81, 16, 1'b1, 1'b1);
    idle(20);
    drain(200);

    // Randomized frames: random baud, data, gaps and occasional framing errors
    for (int n = 0; n < 14; n++) begin
      logic [1:0] s;
      logic [7:0] d;
      bit         bad;
      s   = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      S   = s;
      idle(1);
      send_frame(d, bit_cycles(s), !bad, 1'b1);
      if (bad) begin
        idle($urandom_range(0, 60));
        ser_in = 1'b1;
        idle($urandom_range(3, 20));
      end else begin
        idle($urandom_range(0, 8));
      end
    end
    idle(20);
    drain(2000);
    chk("final_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
